if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the 5-stage pipeline: owns the PC, drives a request/ready instruction-memory port and holds the IF/ID pipeline register. It consumes the control unit's Pcsrc, Stall and Condition_met, and feeds the control unit the Op/Func/Rs/Rt fields of the instruction in ID. A one-entry skid buffer absorbs memory responses that arrive during a load-use stall.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- Clk  in  1  clock, all state updates on rising edge
- Clrn  in  1  synchronous, active-low reset
- Pcsrc  in  2  from control unit: 0 sequential, 2 branch, 3 jump; 1 treated as 0
- Condition_met  in  1  branch in EX taken
- Stall  in  1  load-use stall, hold PC and IF/ID
- Br_target  in  32  branch target from EX
- Imem_req  out  1  fetch request
- Imem_addr  out  32  fetch address, word aligned
- Imem_ready  in  1  response valid this cycle
- Imem_rdata  in  32  instruction word
- If_Inst  out  32  IF/ID instruction
- If_Pc4  out  32  IF/ID PC+4
- If_Valid  out  1  IF/ID holds a real instruction
- Op, Func  out  6 each  If_Inst[31:26], If_Inst[5:0]
- Rs, Rt  out  5 each  If_Inst[25:21], If_Inst[20:16]
- Flush_id  out  1  bubble ID/EX this cycle (= Condition_met)
- Perf_fetch, Perf_flush, Perf_stall  out  32 each  counters (see Configuration)

## Operation
- Redirect priority: Condition_met → target Br_target; else Pcsrc==3 with If_Valid → target {If_Pc4[31:28], If_Inst[25:0], 2'b00}; else none. Redirect beats Stall.
- Any redirect clears IF/ID: If_Inst=0 (NOP), If_Valid=0, If_Pc4=0.
- Stall without redirect: IF/ID and PC unchanged.
- FSM states:
  - BOOT: Imem_req=0; next FETCH.
  - FETCH: Imem_req=1, Imem_addr=PC. On ready: redirect → PC<=target, data dropped, stay; Stall → word to skid, PC<=PC+4, go HOLD; else IF/ID<={rdata, PC+4, 1}, PC<=PC+4. No ready + redirect → Redir_pc<=target, go DROP.
  - DROP: Imem_req=1, address unchanged. Further redirect overwrites Redir_pc. On ready: data dropped, PC<=Redir_pc, go FETCH.
  - HOLD: Imem_req=0. Redirect → skid dropped, PC<=target, go FETCH. Stall low → IF/ID<=skid, go FETCH.
- PC arithmetic 32-bit, wraps 32'hFFFF_FFFC → 0.

## Timing
- Reset (Clrn low at edge): PC=RESET_PC, state BOOT, Imem_req=0, IF/ID cleared, skid empty, counters 0. Reset mid-fetch abandons the request; a late Imem_ready after reset is ignored (BOOT).
- Handshake: Imem_addr stable while Imem_req=1 and Imem_ready=0; one response per request.
- Zero-wait memory: one instruction per cycle; ready→If_Inst latency 1 cycle.
- Redirect penalty: first target fetch request issued the cycle after redirect (FETCH) or after the pending response (DROP).
- Flush_id combinational from Condition_met.

## Configuration
- IF_PERF_EN defined: Perf_fetch increments per instruction written into IF/ID with If_Valid=1; Perf_flush per redirect cycle; Perf_stall per cycle Stall=1; all saturate at 32'hFFFF_FFFF.
- Undefined: counter logic absent, Perf_* tied to 0.

## Structure
- Shared package cpu_pkg: opcode constants (J=6'd2, BEQ=6'd4, BNE=6'd5), Pcsrc encodings (PCSRC_SEQ=0, PCSRC_BR=2, PCSRC_J=3), NOP_INST=32'h0, fetch FSM state enum.
- One sub-module: if_skid_buf (one-entry buffer: load, drain, clear, valid flag).

## Test plan
- Reset with RESET_PC=32'h100, zero-wait memory → Imem_addr 0x100, 0x104, 0x108 on consecutive cycles; If_Valid=0 until first response.
- Jump 0x0800_0040 in ID at If_Pc4=0x1000_0008 → next Imem_addr 0x1000_0100, IF/ID flushed one cycle.
- Condition_met=1 with Br_target=0x200 and Pcsrc=3 same cycle → fetch 0x200, Flush_id=1.
- Stall=1 while response 0xAABB_CCDD arrives → state HOLD, Imem_req=0; Stall low → If_Inst=0xAABB_CCDD next cycle.
- Memory 3-cycle latency, branch to 0x300 on wait cycle 1 → Imem_addr held, response dropped, next request 0x300.
- IF_PERF_EN: 10 fetches, 2 redirects, 3 stall cycles → Perf_fetch=10, Perf_flush=2, Perf_stall=3.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: opcodes, Pcsrc encodings, the NOP word and the
// fetch-state encodings used by if_stage.
package cpu_pkg;

  localparam logic [5:0] J   = 6'd2;
  localparam logic [5:0] BEQ = 6'd4;
  localparam logic [5:0] BNE = 6'd5;

  localparam logic [1:0] PCSRC_SEQ = 2'd0;
  localparam logic [1:0] PCSRC_BR  = 2'd2;
  localparam logic [1:0] PCSRC_J   = 2'd3;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t FS_BOOT  = 2'd0;
  localparam fetch_state_t FS_FETCH = 2'd1;
  localparam fetch_state_t FS_DROP  = 2'd2;
  localparam fetch_state_t FS_HOLD  = 2'd3;

  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [25:0] idx);
    return {pc4[31:28], idx, 2'b00};
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry buffer holding an instruction word that arrived while the
// pipeline was stalled. Drain and clear both empty it.
module if_skid_buf (
  input  logic        clk,
  input  logic        clrn,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  logic [31:0] load_data,
  output logic        valid,
  output logic [31:0] data
);

  always_ff @(posedge clk) begin
    if (!clrn) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clear || drain) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, request/ready imem port, IF/ID register and
// stall skid buffer. Optional performance counters under IF_PERF_EN.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         Clk,
  input  logic         Clrn,
  input  logic [1:0]   Pcsrc,
  input  logic         Condition_met,
  input  logic         Stall,
  input  logic [31:0]  Br_target,
  output logic         Imem_req,
  output logic [31:0]  Imem_addr,
  input  logic         Imem_ready,
  input  logic [31:0]  Imem_rdata,
  output logic [31:0]  If_Inst,
  output logic [31:0]  If_Pc4,
  output logic         If_Valid,
  output logic [5:0]   Op,
  output logic [5:0]   Func,
  output logic [4:0]   Rs,
  output logic [4:0]   Rt,
  output logic         Flush_id,
  output logic [31:0]  Perf_fetch,
  output logic [31:0]  Perf_flush,
  output logic [31:0]  Perf_stall,
  output fetch_state_t dbg_state
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt, pc_plus4;
  logic [31:0]  redir_pc, redir_pc_nxt;
  logic         redir;
  logic [31:0]  redir_tgt;
  logic         ifid_load;
  logic [31:0]  ifid_inst, ifid_pc4;
  logic         skid_load, skid_drain, skid_clear, skid_valid;
  logic [31:0]  skid_data;

  // A taken branch in EX outranks a jump sitting in ID.
  assign redir     = Condition_met || ((Pcsrc == PCSRC_J) && If_Valid);
  assign redir_tgt = Condition_met ? Br_target : jump_target(If_Pc4, If_Inst[25:0]);
  assign pc_plus4  = pc + 32'd4;

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    redir_pc_nxt = redir_pc;
    skid_load    = 1'b0;
    skid_drain   = 1'b0;
    skid_clear   = 1'b0;
    ifid_load    = 1'b0;
    ifid_inst    = Imem_rdata;
    ifid_pc4     = pc_plus4;
    case (state)
      FS_BOOT: state_nxt = FS_FETCH;
      FS_FETCH: begin
        if (Imem_ready) begin
          if (redir) begin
            pc_nxt = redir_tgt;
          end else if (Stall) begin
            skid_load = 1'b1;
            pc_nxt    = pc_plus4;
            state_nxt = FS_HOLD;
          end else begin
            ifid_load = 1'b1;
            pc_nxt    = pc_plus4;
          end
        end else if (redir) begin
          redir_pc_nxt = redir_tgt;
          state_nxt    = FS_DROP;
        end
      end
      FS_DROP: begin
        // The outstanding response belongs to the abandoned path.
        if (redir) redir_pc_nxt = redir_tgt;
        if (Imem_ready) begin
          pc_nxt    = redir_pc_nxt;
          state_nxt = FS_FETCH;
        end
      end
      FS_HOLD: begin
        if (redir) begin
          skid_clear = 1'b1;
          pc_nxt     = redir_tgt;
          state_nxt  = FS_FETCH;
        end else if (!Stall) begin
          // PC already advanced past the buffered word, so it is that word's PC+4.
          skid_drain = 1'b1;
          ifid_load  = skid_valid;
          ifid_inst  = skid_data;
          ifid_pc4   = pc;
          state_nxt  = FS_FETCH;
        end
      end
      default: state_nxt = FS_BOOT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      state    <= FS_BOOT;
      pc       <= RESET_PC;
      redir_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      redir_pc <= redir_pc_nxt;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Clrn || redir) begin
      If_Inst  <= NOP_INST;
      If_Pc4   <= '0;
      If_Valid <= 1'b0;
    end else if (ifid_load) begin
      If_Inst  <= ifid_inst;
      If_Pc4   <= ifid_pc4;
      If_Valid <= 1'b1;
    end else if (!Stall) begin
      If_Inst  <= NOP_INST;
      If_Pc4   <= '0;
      If_Valid <= 1'b0;
    end
  end

  if_skid_buf u_skid (
    .clk       (Clk),
    .clrn      (Clrn),
    .load      (skid_load),
    .drain     (skid_drain),
    .clear     (skid_clear),
    .load_data (Imem_rdata),
    .valid     (skid_valid),
    .data      (skid_data)
  );

  assign Imem_req  = (state == FS_FETCH) || (state == FS_DROP);
  assign Imem_addr = pc;
  assign Op        = If_Inst[31:26];
  assign Func      = If_Inst[5:0];
  assign Rs        = If_Inst[25:21];
  assign Rt        = If_Inst[20:16];
  assign Flush_id  = Condition_met;
  assign dbg_state = state;

`ifdef IF_PERF_EN
  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      Perf_fetch <= '0;
      Perf_flush <= '0;
      Perf_stall <= '0;
    end else begin
      if (ifid_load && !redir && (Perf_fetch != 32'hFFFF_FFFF)) Perf_fetch <= Perf_fetch + 32'd1;
      if (redir && (Perf_flush != 32'hFFFF_FFFF)) Perf_flush <= Perf_flush + 32'd1;
      if (Stall && (Perf_stall != 32'hFFFF_FFFF)) Perf_stall <= Perf_stall + 32'd1;
    end
  end
`else
  assign Perf_fetch = '0;
  assign Perf_flush = '0;
  assign Perf_stall = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by randomized traffic, all
// checked each cycle against a behavioural fetch model.
module tb_if_stage;
  import cpu_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic         Clk = 1'b0;
  logic         Clrn = 1'b0;
  logic [1:0]   Pcsrc = '0;
  logic         Condition_met = 1'b0;
  logic         Stall = 1'b0;
  logic [31:0]  Br_target = '0;
  logic         Imem_req;
  logic [31:0]  Imem_addr;
  logic         Imem_ready = 1'b0;
  logic [31:0]  Imem_rdata = '0;
  logic [31:0]  If_Inst, If_Pc4;
  logic         If_Valid;
  logic [5:0]   Op, Func;
  logic [4:0]   Rs, Rt;
  logic         Flush_id;
  logic [31:0]  Perf_fetch, Perf_flush, Perf_stall;
  fetch_state_t dbg_state;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .Clk(Clk), .Clrn(Clrn), .Pcsrc(Pcsrc), .Condition_met(Condition_met),
    .Stall(Stall), .Br_target(Br_target), .Imem_req(Imem_req),
    .Imem_addr(Imem_addr), .Imem_ready(Imem_ready), .Imem_rdata(Imem_rdata),
    .If_Inst(If_Inst), .If_Pc4(If_Pc4), .If_Valid(If_Valid), .Op(Op),
    .Func(Func), .Rs(Rs), .Rt(Rt), .Flush_id(Flush_id),
    .Perf_fetch(Perf_fetch), .Perf_flush(Perf_flush), .Perf_stall(Perf_stall),
    .dbg_state(dbg_state)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem_ovr [logic [31:0]];

  // Behavioural model of the fetch stage.
  bit          m_known = 1'b0;
  bit          m_boot = 1'b1;
  bit          m_req = 1'b0;
  bit          m_drop = 1'b0;
  logic [31:0] m_drop_addr = '0;
  logic [31:0] m_skid [$];
  logic [31:0] m_pc = '0, m_inst = '0, m_pc4 = '0;
  bit          m_valid = 1'b0;
  logic [31:0] m_pf = '0, m_pfl = '0, m_ps = '0;
  logic        last_flush = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h0F0F_3C3C;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic compare_all();
    logic [31:0] ef, efl, es;
    if (!m_known) return;
    check("req", Imem_req, m_req);
    if (m_req) check("addr", Imem_addr, m_pc);
    check("inst", If_Inst, m_inst);
    check("pc4", If_Pc4, m_pc4);
    check("valid", If_Valid, m_valid);
    check("op", Op, m_inst >> 26);
    check("func", Func, m_inst & 32'h3F);
    check("rs", Rs, (m_inst >> 21) & 32'h1F);
    check("rt", Rt, (m_inst >> 16) & 32'h1F);
    check("flush_id", Flush_id, Condition_met);
`ifdef IF_PERF_EN
    ef = m_pf; efl = m_pfl; es = m_ps;
`else
    ef = '0; efl = '0; es = '0;
`endif
    check("perf_fetch", Perf_fetch, ef);
    check("perf_flush", Perf_flush, efl);
    check("perf_stall", Perf_stall, es);
  endtask

  task automatic load_ifid(input logic [31:0] inst, input logic [31:0] pc4);
    m_inst = inst; m_pc4 = pc4; m_valid = 1'b1;
    m_pf = sat_inc(m_pf);
  endtask

  task automatic model_step();
    bit redir, got, loaded;
    logic [31:0] tgt;
    if (!Clrn) begin
      m_known = 1'b1; m_boot = 1'b1; m_drop = 1'b0; m_skid.delete();
      m_pc = RST_PC; m_inst = '0; m_pc4 = '0; m_valid = 1'b0;
      m_pf = '0; m_pfl = '0; m_ps = '0; m_req = 1'b0;
      return;
    end
    redir  = Condition_met || (Pcsrc == 2'd3 && m_valid);
    tgt    = Condition_met ? Br_target : {m_pc4[31:28], m_inst[25:0], 2'b00};
    got    = m_req && Imem_ready;
    loaded = 1'b0;
    if (redir) m_pfl = sat_inc(m_pfl);
    if (Stall) m_ps = sat_inc(m_ps);
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_drop) begin
      if (redir) m_drop_addr = tgt;
      if (got) begin m_pc = m_drop_addr; m_drop = 1'b0; end
    end else if (m_skid.size() != 0) begin
      if (redir) begin
        m_skid.delete(); m_pc = tgt;
      end else if (!Stall) begin
        load_ifid(m_skid.pop_front(), m_pc); loaded = 1'b1;
      end
    end else if (got) begin
      if (redir) m_pc = tgt;
      else if (Stall) begin m_skid.push_back(mem_word(m_pc)); m_pc = m_pc + 32'd4; end
      else begin load_ifid(mem_word(m_pc), m_pc + 32'd4); loaded = 1'b1; m_pc = m_pc + 32'd4; end
    end else if (redir) begin
      m_drop = 1'b1; m_drop_addr = tgt;
    end
    if (redir || (!loaded && !Stall)) begin
      m_inst = '0; m_pc4 = '0; m_valid = 1'b0;
    end
    m_req = !m_boot && (m_skid.size() == 0);
  endtask

  // One clock: apply inputs after the edge, check at negedge, advance model.
  task automatic drive(input bit rst_n, input bit st, input bit cm,
                       input logic [1:0] ps, input logic [31:0] bt, input bit rdy);
    Clrn = rst_n; Stall = st; Condition_met = cm; Pcsrc = ps; Br_target = bt;
    Imem_ready = rdy && (m_req || m_boot || !rst_n);
    Imem_rdata = mem_word(m_pc);
    @(negedge Clk);
    last_flush = Flush_id;
    compare_all();
    model_step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input bit rdy);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, rdy);
  endtask

  initial begin
    bit r, st, cm, rdy;
    logic [1:0] ps;
    logic [31:0] bt;

    mem_ovr[32'h1000_0004] = 32'h0800_0040;
    mem_ovr[32'h0000_0200] = 32'hAABB_CCDD;

    @(posedge Clk); #1;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
    check("boot_req", Imem_req, 1'b0);
    check("boot_valid", If_Valid, 1'b0);
    check("boot_state", dbg_state, FS_BOOT);

    // Late ready in BOOT must be ignored; then zero-wait streaming.
    idle(1'b1);
    check("seq_addr0", Imem_addr, 32'h100);
    check("seq_valid0", If_Valid, 1'b0);
    idle(1'b1);
    check("seq_addr1", Imem_addr, 32'h104);
    check("seq_inst0", If_Inst, mem_word(32'h100));
    check("seq_pc4_0", If_Pc4, 32'h104);
    idle(1'b1);
    check("seq_addr2", Imem_addr, 32'h108);

    // Jump in ID.
    drive(1'b1, 1'b0, 1'b1, 2'd2, 32'h1000_0004, 1'b1);
    idle(1'b1);
    check("j_inst", If_Inst, 32'h0800_0040);
    check("j_pc4", If_Pc4, 32'h1000_0008);
    drive(1'b1, 1'b0, 1'b0, 2'd3, 32'h0, 1'b1);
    check("j_addr", Imem_addr, 32'h1000_0100);
    check("j_flushed", If_Valid, 1'b0);
    idle(1'b1);
    check("j_refill", If_Valid, 1'b1);
    check("j_refill_pc4", If_Pc4, 32'h1000_0104);

    // Branch and jump together: branch wins.
    drive(1'b1, 1'b0, 1'b1, 2'd3, 32'h200, 1'b1);
    check("bj_flush_id", last_flush, 1'b1);
    check("bj_addr", Imem_addr, 32'h200);

    // Response during stall goes to the skid buffer.
    drive(1'b1, 1'b1, 1'b0, 2'd0, 32'h0, 1'b1);
    check("hold_state", dbg_state, FS_HOLD);
    check("hold_req", Imem_req, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 2'd0, 32'h0, 1'b0);
    check("hold_state2", dbg_state, FS_HOLD);
    idle(1'b0);
    check("skid_inst", If_Inst, 32'hAABB_CCDD);
    check("skid_pc4", If_Pc4, 32'h204);
    check("skid_state", dbg_state, FS_FETCH);

    // Branch during a 3-cycle memory wait.
    drive(1'b1, 1'b0, 1'b1, 2'd0, 32'h300, 1'b0);
    check("drop_addr0", Imem_addr, 32'h204);
    check("drop_req", Imem_req, 1'b1);
    idle(1'b0);
    check("drop_addr1", Imem_addr, 32'h204);
    idle(1'b1);
    check("drop_next", Imem_addr, 32'h300);
    check("drop_valid", If_Valid, 1'b0);
    idle(1'b1);
    check("drop_pc4", If_Pc4, 32'h304);

    // PC wrap.
    drive(1'b1, 1'b0, 1'b1, 2'd0, 32'hFFFF_FFFC, 1'b1);
    idle(1'b1);
    check("wrap_addr", Imem_addr, 32'h0);
    check("wrap_pc4", If_Pc4, 32'h0);

    // Reset while a request is outstanding.
    idle(1'b0);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
    check("rst_mid_req", Imem_req, 1'b0);
    check("rst_mid_valid", If_Valid, 1'b0);
    idle(1'b1);
    check("rst_mid_addr", Imem_addr, RST_PC);
    check("rst_mid_valid2", If_Valid, 1'b0);

    // Counter scenario: 10 fetches, 2 redirects, 3 stall cycles.
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 10; i++) idle(1'b1);
    drive(1'b1, 1'b0, 1'b1, 2'd0, 32'h400, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 2'd0, 32'h400, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 2'd0, 32'h0, 1'b0);
`ifdef IF_PERF_EN
    check("perf_fetch10", Perf_fetch, 32'd10);
    check("perf_flush2", Perf_flush, 32'd2);
    check("perf_stall3", Perf_stall, 32'd3);
`else
    check("perf_off_fetch", Perf_fetch, 32'd0);
    check("perf_off_flush", Perf_flush, 32'd0);
    check("perf_off_stall", Perf_stall, 32'd0);
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      r   = ($urandom_range(0, 199) != 0);
      st  = ($urandom_range(0, 4) == 0);
      cm  = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      ps  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      bt  = $urandom() & 32'hFFFF_FFFC;
      drive(r, st, cm, ps, bt, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
